// File: rtl/eth_gmii_tx_framer.sv
// Ethernet GMII/MII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS and inter-frame gap.
// clk_enable is the byte-time strobe, so the same core serves GMII (tied high) and MII (1-in-2) rates.
module eth_gmii_tx_framer #(
    parameter int unsigned ENABLE_PADDING   = 1,
    parameter int unsigned MIN_FRAME_LENGTH = 64,
    parameter int unsigned IFG_BYTES        = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic [7:0] frame_in_tdata,
    input  logic       frame_in_tvalid,
    output logic       frame_in_tready,
    input  logic       frame_in_tlast,
    input  logic       frame_in_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       start_packet,
    output logic       error_underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG,
        S_DRAIN
    } state_t;

    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [7:0]  IFG_LAST   = 8'(IFG_BYTES - 1);
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        start_q, start_d;
    logic        uf_q, uf_d;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        txd_d   = txd_q;
        tx_en_d = tx_en_q;
        tx_er_d = tx_er_q;
        start_d = 1'b0;
        uf_d    = 1'b0;
        if (clk_enable) begin
            txd_d   = '0;
            tx_en_d = 1'b0;
            tx_er_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (frame_in_tvalid) begin
                        state_d = S_PREAMBLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                        crc_d   = '1;
                    end
                end
                S_PREAMBLE: begin
                    tx_en_d = 1'b1;
                    txd_d   = (idx_q == 8'd7) ? 8'hD5 : 8'h55;
                    start_d = (idx_q == 8'd0);
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == 8'd7) begin
                        state_d = S_PAYLOAD;
                        idx_d   = '0;
                    end
                end
                S_PAYLOAD: begin
                    tx_en_d = 1'b1;
                    if (frame_in_tvalid) begin
                        txd_d = frame_in_tdata;
                        crc_d = crc_byte(crc_q, frame_in_tdata);
                        cnt_d = cnt_inc;
                        if (frame_in_tlast) begin
                            idx_d = '0;
                            if (frame_in_tuser) begin
                                tx_er_d = 1'b1;
                                state_d = S_IFG;
                            end else if (ENABLE_PADDING != 0 && cnt_inc < PAD_TARGET) begin
                                state_d = S_PAD;
                            end else begin
                                state_d = S_FCS;
                            end
                        end
                    end else begin
                        tx_er_d = 1'b1;
                        uf_d    = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
                S_PAD: begin
                    tx_en_d = 1'b1;
                    crc_d   = crc_byte(crc_q, 8'h00);
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= PAD_TARGET) begin
                        state_d = S_FCS;
                        idx_d   = '0;
                    end
                end
                S_FCS: begin
                    tx_en_d = 1'b1;
                    txd_d   = ~crc_q[{idx_q[1:0], 3'b000} +: 8];
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == 8'd3) begin
                        state_d = S_IFG;
                        idx_d   = '0;
                    end
                end
                S_IFG: begin
                    idx_d = idx_q + 8'd1;
                    // A waiting frame starts straight from the last gap byte so back-to-back gaps are exactly IFG_BYTES.
                    if (idx_q == IFG_LAST) begin
                        idx_d = '0;
                        if (frame_in_tvalid) begin
                            state_d = S_PREAMBLE;
                            cnt_d   = '0;
                            crc_d   = '1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (frame_in_tvalid && frame_in_tlast) begin
                        state_d = S_IFG;
                        idx_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= '1;
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            start_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            start_q <= start_d;
            uf_q    <= uf_d;
        end
    end

    assign frame_in_tready = clk_enable && (state_q == S_PAYLOAD || state_q == S_DRAIN);
    assign gmii_txd        = txd_q;
    assign gmii_tx_en      = tx_en_q;
    assign gmii_tx_er      = tx_er_q;
    assign busy            = (state_q != S_IDLE);
    assign start_packet    = start_q;
    assign error_underflow = uf_q;

endmodule
